// File: rtl/reg_bank.sv
// reg_bank: NCH channels of WIDTH bits that can hold, masked parallel-load,
// shift as a channel chain (sin -> ch0 -> ... -> ch[NCH-1]) or rotate, plus a
// saturating counter of the cycles that modified the bank.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (channels <= RST_VAL, count <= 0)
//   clr      synchronous clear, overrides mode
//   mode     00 hold, 01 load, 10 shift, 11 rotate
//   ld_en    per-channel load enable (mode 01 only)
//   d        parallel data, channel k = d[k*WIDTH +: WIDTH]
//   sin      serial input to channel 0 in shift mode
//   q        registered channel contents, same packing as d
//   sout     channel NCH-1 contents
//   upd_cnt  saturating count of update cycles
module reg_bank #(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      NCH     = 2,
   parameter int unsigned      CNT_W   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [1:0]             mode,
   input  logic [NCH-1:0]         ld_en,
   input  logic [NCH*WIDTH-1:0]   d,
   input  logic [WIDTH-1:0]       sin,
   output logic [NCH*WIDTH-1:0]   q,
   output logic [WIDTH-1:0]       sout,
   output logic [CNT_W-1:0]       upd_cnt
);

   localparam logic [1:0]       MODE_HOLD  = 2'b00;
   localparam logic [1:0]       MODE_LOAD  = 2'b01;
   localparam logic [1:0]       MODE_SHIFT = 2'b10;
   localparam logic [1:0]       MODE_ROT   = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic [NCH-1:0][WIDTH-1:0] r_ch;
   logic [NCH-1:0][WIDTH-1:0] w_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic                      w_upd;

   // Per-channel next value; w_prev is the upstream neighbour in the chain.
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [WIDTH-1:0] w_prev;

      if (k == 0) begin : g_head
         // Head of the chain takes sin when shifting, the tail when rotating.
         assign w_prev = (mode == MODE_ROT) ? r_ch[NCH-1] : sin;
      end else begin : g_tail
         assign w_prev = r_ch[k-1];
      end

      assign w_nxt[k] = ((mode == MODE_LOAD) && ld_en[k]) ? d[k*WIDTH +: WIDTH] :
                        ((mode == MODE_SHIFT) || (mode == MODE_ROT)) ? w_prev :
                        r_ch[k];
   end

   // A cycle counts when it is an update, whether or not any value changes.
   assign w_upd = ((mode == MODE_LOAD) && (|ld_en)) ||
                  (mode == MODE_SHIFT) || (mode == MODE_ROT);

   // Channel storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ch <= {NCH{RST_VAL}};
      end else if (clr) begin
         r_ch <= {NCH{RST_VAL}};
      end else if (mode != MODE_HOLD) begin
         r_ch <= w_nxt;
      end
   end

   // Saturating update counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (w_upd && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign q       = r_ch;
   assign sout    = r_ch[NCH-1];
   assign upd_cnt = r_cnt;

endmodule
